// File: rtl/rr_operand_arbiter.sv
// rr_operand_arbiter: round-robin sharing of one req/ack token source among num_clients requesters.
module rr_operand_arbiter #(
  parameter int num_clients = 4,
  parameter int data_width  = 32,
  parameter int sel_width   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [num_clients-1:0] cl_req,
  output logic [num_clients-1:0] cl_ack,
  output logic [data_width-1:0]  cl_dout,
  output logic                   up_req,
  input  logic                   up_ack,
  input  logic [data_width-1:0]  up_din,
  output logic [sel_width-1:0]   grant,
  output logic                   busy,
  output logic [31:0]            served_count
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t                 r_state, w_next;
  logic [sel_width-1:0]   r_last, r_grant, w_pick;
  logic [num_clients-1:0] r_ack, w_pending;
  logic [data_width-1:0]  r_dout;
  logic                   r_up_req, r_busy, w_found;
  logic [31:0]            r_count;
  // Lowest pending index above last wins; otherwise wrap to the lowest pending index at or below last.
  always_comb begin
    w_pending = cl_req & ~r_ack;
    w_found   = |w_pending;
    w_pick    = '0;
    for (int i = num_clients - 1; i >= 0; i--)
      if (w_pending[i] && i <= int'(r_last)) w_pick = sel_width'(i);
    for (int i = num_clients - 1; i >= 0; i--)
      if (w_pending[i] && i > int'(r_last)) w_pick = sel_width'(i);
  end
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_found ? WAIT : IDLE;
    if (r_state == WAIT) w_next = up_ack ? DONE : WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last   <= sel_width'(num_clients - 1);
      r_grant  <= '0;
      r_ack    <= '0;
      r_dout   <= '0;
      r_up_req <= 1'b0;
      r_busy   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_grant  <= w_pick;
        r_up_req <= 1'b1;
        r_busy   <= 1'b1;
      end
      if (r_state == WAIT && up_ack) begin
        r_up_req <= 1'b0;
        r_dout   <= up_din;
        r_ack    <= num_clients'(1) << r_grant;
        r_count  <= r_count + 32'd1;
      end
      if (r_state == DONE) begin
        r_ack  <= '0;
        r_last <= r_grant;
        r_busy <= 1'b0;
      end
    end
  end
  assign cl_ack       = r_ack;
  assign cl_dout      = r_dout;
  assign up_req       = r_up_req;
  assign grant        = r_grant;
  assign busy         = r_busy;
  assign served_count = r_count;
endmodule
